// File: rtl/pump_pkg.sv
// pump_pkg: shared state encoding and display-range constants for the pump nozzle path.
package pump_pkg;
  localparam int LIT_W = 24;
  localparam int MAX_LIT = 9999999;
  typedef enum logic [1:0] {IDLE, ARMED, PUMPING, DONE} state_t;
endpackage

// File: rtl/pump_dispense_ctrl_flow_prescaler.sv
// flow_prescaler: modulo-PULSE_PER_UNIT flow pulse counter with a combinational unit_tick on the wrapping pulse.
module flow_prescaler #(
  parameter int PULSE_PER_UNIT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic unit_tick
);
  localparam int CW = $clog2(PULSE_PER_UNIT);
  logic [CW-1:0] cnt;
  assign unit_tick = en && !clr && cnt == CW'(PULSE_PER_UNIT - 1);
  always_ff @(posedge clk) begin
    if (!rst_n || clr) cnt <= '0;
    else if (en) cnt <= unit_tick ? '0 : cnt + CW'(1);
  end
endmodule

// File: rtl/pump_dispense_ctrl.sv
// pump_dispense_ctrl: nozzle sequencing FSM, pump gating and dispensed-volume count.
// Optional no-flow timeout built when PUMP_DISPENSE_CTRL_TIMEOUT_EN is defined.
module pump_dispense_ctrl #(
  parameter int LIT_W = pump_pkg::LIT_W,
  parameter int MAX_LIT = pump_pkg::MAX_LIT,
  parameter int PULSE_PER_UNIT = 10,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             nozzle_up,
  input  logic [LIT_W-1:0] preset,
  input  logic             flow_pulse,
  output logic             pump_en,
  output logic [LIT_W-1:0] lit,
  output logic             disp_en,
  output logic             busy,
  output logic             done,
  output logic             fault
);
  import pump_pkg::*;
  state_t state, state_n;
  logic [LIT_W-1:0] preset_q;
  logic pulse, tick, reach, tmo, accept, reject;
  assign pulse  = flow_pulse && state == PUMPING;
  assign accept = state == IDLE && start && preset != '0 && preset <= LIT_W'(MAX_LIT);
  assign reject = state == IDLE && start && !accept;
  assign reach  = tick && (lit + LIT_W'(1)) == preset_q;
  // Held clear outside PUMPING, so partial counts vanish on leaving it.
  flow_prescaler #(.PULSE_PER_UNIT(PULSE_PER_UNIT)) u_prescaler (
    .clk,
    .rst_n,
    .clr(state != PUMPING),
    .en(pulse),
    .unit_tick(tick)
  );
`ifdef PUMP_DISPENSE_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  always_ff @(posedge clk) begin
    if (!rst_n || state != PUMPING || flow_pulse) tcnt <= '0;
    else tcnt <= tcnt + TW'(1);
  end
  assign tmo = state == PUMPING && !flow_pulse && tcnt == TW'(TIMEOUT_CYC - 1);
`else
  localparam int unused_timeout = TIMEOUT_CYC;
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? ARMED : IDLE;
      ARMED:   state_n = stop ? DONE : nozzle_up ? PUMPING : ARMED;
      PUMPING: state_n = (stop || !nozzle_up || reach || tmo) ? DONE : PUMPING;
      DONE:    state_n = nozzle_up ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pump_en  <= 1'b0;
      lit      <= '0;
      preset_q <= '0;
      disp_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state   <= state_n;
      pump_en <= state_n == PUMPING;
      busy    <= state_n == ARMED || state_n == PUMPING;
      done    <= state_n == DONE && state != DONE;
      fault   <= reject || tmo;
      if (accept) begin
        preset_q <= preset;
        lit      <= '0;
        disp_en  <= 1'b1;
      end else if (tick) lit <= lit + LIT_W'(1);
    end
  end
endmodule

// File: tb/tb_pump_dispense_ctrl.sv
// tb_pump_dispense_ctrl: scoreboard bench; stimulus queues expected outputs, a negedge monitor compares.
module tb_pump_dispense_ctrl;
  typedef struct packed {
    logic done, fault, pump_en, busy, disp_en;
    logic [23:0] lit;
  } obs_t;
  typedef struct {
    string nm;
    obs_t v;
  } exp_t;

  logic clk = 0, rst_n = 0, start = 0, stop = 0, nozzle_up = 0, flow_pulse = 0;
  logic [23:0] preset = '0;
  logic pump_en, disp_en, busy, done, fault;
  logic [23:0] lit;
  logic probe = 0;
  obs_t cur;
  exp_t ev_q[$], sn_q[$];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  pump_dispense_ctrl #(.PULSE_PER_UNIT(10), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .nozzle_up(nozzle_up),
    .preset(preset), .flow_pulse(flow_pulse), .pump_en(pump_en), .lit(lit),
    .disp_en(disp_en), .busy(busy), .done(done), .fault(fault)
  );

  assign cur = {done, fault, pump_en, busy, disp_en, lit};

  // fields: done fault pump_en busy disp_en lit
  function automatic obs_t o(input logic d, f, p, b, e, input int l);
    return {d, f, p, b, e, 24'(l)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    flow_pulse = 1;
    tick();
    flow_pulse = 0;
    tick();
  endtask

  task automatic expect_ev(input string nm, input obs_t v);
    ev_q.push_back('{nm, v});
  endtask

  task automatic snap(input string nm, input obs_t v);
    sn_q.push_back('{nm, v});
    probe = 1;
    @(negedge clk);
    #1;
    probe = 0;
  endtask

  task automatic do_start(input int p);
    preset = 24'(p);
    start = 1;
    tick();
    start = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n && (done || fault)) begin
      n_cmp++;
      if (ev_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got %h, required no done/fault", cur);
      end else begin
        exp_t e;
        e = ev_q.pop_front();
        if (cur !== e.v) begin
          n_bad++;
          $display("FAIL %s: got %h, required %h", e.nm, cur, e.v);
        end
      end
    end
    if (probe) begin
      exp_t e;
      e = sn_q.pop_front();
      n_cmp++;
      if (cur !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h, required %h", e.nm, cur, e.v);
      end
    end
  end

  initial begin
    repeat (3) tick();
    snap("reset_values", o(0, 0, 0, 0, 0, 0));
    rst_n = 1;
    tick();

    // preset 3, 30 pulses
    do_start(3);
    snap("t1_armed", o(0, 0, 0, 1, 1, 0));
    nozzle_up = 1;
    tick();
    snap("t1_pumping", o(0, 0, 1, 1, 1, 0));
    for (int i = 1; i <= 30; i++) begin
      if (i == 30) expect_ev("t1_done", o(1, 0, 0, 0, 1, 3));
      pulse();
      if (i == 9) snap("t1_lit_p9", o(0, 0, 1, 1, 1, 0));
      if (i == 10) snap("t1_lit_p10", o(0, 0, 1, 1, 1, 1));
      if (i == 20) snap("t1_lit_p20", o(0, 0, 1, 1, 1, 2));
    end
    snap("t1_done_hold", o(0, 0, 0, 0, 1, 3));
    nozzle_up = 0;
    tick();
    snap("t1_idle_hold", o(0, 0, 0, 0, 1, 3));

    // rejected presets, then MAX_LIT accepted and stop beats nozzle_up in ARMED
    expect_ev("t2_fault_zero", o(0, 1, 0, 0, 1, 3));
    do_start(0);
    tick();
    snap("t2_idle_after_zero", o(0, 0, 0, 0, 1, 3));
    expect_ev("t2_fault_over", o(0, 1, 0, 0, 1, 3));
    do_start(10000000);
    tick();
    snap("t2_idle_after_over", o(0, 0, 0, 0, 1, 3));
    do_start(9999999);
    snap("t2_max_armed", o(0, 0, 0, 1, 1, 0));
    expect_ev("t2_stop_armed_done", o(1, 0, 0, 0, 1, 0));
    stop = 1;
    nozzle_up = 1;
    tick();
    stop = 0;
    nozzle_up = 0;
    tick();

    // preset 100, stop alongside pulse 26
    do_start(100);
    nozzle_up = 1;
    tick();
    repeat (25) pulse();
    snap("t3_lit_25", o(0, 0, 1, 1, 1, 2));
    expect_ev("t3_stop_done", o(1, 0, 0, 0, 1, 2));
    flow_pulse = 1;
    stop = 1;
    tick();
    flow_pulse = 0;
    stop = 0;
    nozzle_up = 0;
    tick();

    // preset 50, nozzle down after 15 pulses; prescaler must start fresh
    do_start(50);
    nozzle_up = 1;
    tick();
    repeat (15) pulse();
    snap("t4_lit_15", o(0, 0, 1, 1, 1, 1));
    expect_ev("t4_nozzle_done", o(1, 0, 0, 0, 1, 1));
    nozzle_up = 0;
    tick();
    repeat (12) pulse();
    snap("t4_pulses_ignored", o(0, 0, 0, 0, 1, 1));

    // no-flow behaviour
    do_start(50);
    nozzle_up = 1;
    tick();
`ifdef PUMP_DISPENSE_CTRL_TIMEOUT_EN
    expect_ev("t5_timeout", o(1, 1, 0, 0, 1, 0));
    repeat (99) tick();
    snap("t5_before_timeout", o(0, 0, 1, 1, 1, 0));
    tick();
`else
    repeat (150) tick();
    snap("t5_no_timeout", o(0, 0, 1, 1, 1, 0));
    expect_ev("t5_stop_done", o(1, 0, 0, 0, 1, 0));
    stop = 1;
    tick();
    stop = 0;
`endif
    nozzle_up = 0;
    tick();
    snap("t5_idle", o(0, 0, 0, 0, 1, 0));

    // reset during PUMPING at lit 7
    do_start(50);
    nozzle_up = 1;
    tick();
    repeat (70) pulse();
    snap("t6_lit_7", o(0, 0, 1, 1, 1, 7));
    rst_n = 0;
    tick();
    snap("t6_reset_mid", o(0, 0, 0, 0, 0, 0));
    rst_n = 1;
    nozzle_up = 0;
    repeat (3) tick();

    n_cmp++;
    if (ev_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_events: got %0d pending, required 0", ev_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
